gather_dat_128_1024: RTL and testbench

//  Collects a stream of 128-bit lane beats into 1024-bit words. Beats are packed low slot first.
//  It is the write-side counterpart of the funnel_dat tree, rebuilding wide words for the piston datapath.

---
 rtl/piston_pkg.sv | 18 +
 rtl/gather_out_reg.sv | 33 +++
 rtl/gather_dat_128_1024.sv | 109 ++++++++++
 tb/tb_gather_dat_128_1024.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piston_pkg.sv
// Shared lane geometry and gather-mode helpers for the piston datapath.
package piston_pkg;

  localparam int LANE_W = 128;
  localparam int LANES  = 8;

  typedef enum logic [1:0] {
    G1 = 2'd0,
    G2 = 2'd1,
    G4 = 2'd2,
    G8 = 2'd3
  } gather_mode_e;

  function automatic logic [3:0] beats_of(gather_mode_e m);
    return 4'd1 << m;
  endfunction

endpackage

// File: rtl/gather_out_reg.sv
// Output holding register for gathered words: valid/ready handshake with a dat+beats payload.
module gather_out_reg
  import piston_pkg::*;
#(
  parameter int W = LANE_W * LANES
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_dat,
  input  logic [3:0]   load_beats,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dat,
  output logic [3:0]   beats
);

  // A load in the same cycle as a drain wins, so back-to-back words have no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dat   <= '0;
      beats <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dat   <= load_dat;
      beats <= load_beats;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gather_dat_128_1024.sv
// Packs 128-bit lane beats into 1024-bit words, low slot first, with early close on t_0_last.
// Optional word counter on i_0_cnt is built only when GATHER_CNT_EN is defined.
module gather_dat_128_1024 #(
  parameter int LANE_W = piston_pkg::LANE_W,
  parameter int LANES  = piston_pkg::LANES,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [7:0]                cfg_mode,
  output logic [7:0]                mode,
  input  logic [LANE_W-1:0]         t_0_dat,
  input  logic                      t_0_valid,
  input  logic                      t_0_last,
  output logic                      t_0_ready,
  output logic [LANE_W*LANES-1:0]   i_0_dat,
  output logic [3:0]                i_0_beats,
  output logic                      i_0_valid,
  input  logic                      i_0_ready
`ifdef GATHER_CNT_EN
  ,
  output logic [CNT_W-1:0]          i_0_cnt
`endif
);
  import piston_pkg::*;

  localparam int W = LANE_W * LANES;

  logic [1:0]   mode_reg;
  logic [2:0]   slot_reg;
  logic [W-1:0] acc_reg;
  logic [W-1:0] merged;
  gather_mode_e cur_mode;
  logic [3:0]   n_beats;
  logic         completing;
  logic         accept;
  logic         unused_cfg;

  assign unused_cfg = ^cfg_mode[7:2];

  // On the first beat of a word the incoming cfg_mode decides the word length.
  always_comb begin
    cur_mode   = (slot_reg == 3'd0) ? gather_mode_e'(cfg_mode[1:0]) : gather_mode_e'(mode_reg);
    n_beats    = beats_of(cur_mode);
    completing = ({1'b0, slot_reg} == (n_beats - 4'd1)) || t_0_last;
    t_0_ready  = reset_n && (!completing || !i_0_valid || i_0_ready);
    accept     = t_0_valid && t_0_ready;
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_slot
      assign merged[gi*LANE_W +: LANE_W] =
        (slot_reg == 3'(gi)) ? t_0_dat : acc_reg[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_reg <= 2'd0;
      slot_reg <= 3'd0;
      acc_reg  <= '0;
    end else if (accept) begin
      if (slot_reg == 3'd0) begin
        mode_reg <= cfg_mode[1:0];
      end
      if (completing) begin
        acc_reg  <= '0;
        slot_reg <= 3'd0;
      end else begin
        acc_reg  <= merged;
        slot_reg <= slot_reg + 3'd1;
      end
    end
  end

  assign mode = {6'b0, mode_reg};

  gather_out_reg #(
    .W(W)
  ) u_out (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept && completing),
    .load_dat  (merged),
    .load_beats({1'b0, slot_reg} + 4'd1),
    .ready     (i_0_ready),
    .valid     (i_0_valid),
    .dat       (i_0_dat),
    .beats     (i_0_beats)
  );

`ifdef GATHER_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (i_0_valid && i_0_ready) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign i_0_cnt = cnt_reg;
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_gather_dat_128_1024.sv
// Self-checking bench for gather_dat_128_1024: directed scenarios plus random traffic vs a queue model.
module tb_gather_dat_128_1024;
  localparam int LW = 128;
  localparam int W  = 1024;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    cfg_mode = '0;
  logic [7:0]    mode;
  logic [LW-1:0] t_0_dat = '0;
  logic          t_0_valid = 1'b0;
  logic          t_0_last = 1'b0;
  logic          t_0_ready;
  logic [W-1:0]  i_0_dat;
  logic [3:0]    i_0_beats;
  logic          i_0_valid;
  logic          i_0_ready = 1'b0;
`ifdef GATHER_CNT_EN
  logic [15:0]   i_0_cnt;
`endif

  always #5 clk = ~clk;

  gather_dat_128_1024 dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cfg_mode (cfg_mode),
    .mode     (mode),
    .t_0_dat  (t_0_dat),
    .t_0_valid(t_0_valid),
    .t_0_last (t_0_last),
    .t_0_ready(t_0_ready),
    .i_0_dat  (i_0_dat),
    .i_0_beats(i_0_beats),
    .i_0_valid(i_0_valid),
    .i_0_ready(i_0_ready)
`ifdef GATHER_CNT_EN
    ,
    .i_0_cnt  (i_0_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] d;
    int           b;
  } word_t;

  typedef struct {
    bit            v;
    logic [LW-1:0] d;
    bit            l;
    logic [7:0]    c;
    bit            r;
    int            er;  // -1: no fixed expectation on t_0_ready
  } stim_t;

  // Reference model: beats of the open word, the held output word, drained words.
  logic [LW-1:0] cur_q[$];
  word_t         done_q[$];
  int            n_lat;
  logic [1:0]    m_mode;
  bit            mv;
  logic [W-1:0]  mdat;
  int            mbeats;
  int            mcnt;

  function automatic stim_t mk(bit v, logic [LW-1:0] d, bit l, logic [7:0] c, bit r, int er);
    stim_t s;
    s.v = v; s.d = d; s.l = l; s.c = c; s.r = r; s.er = er;
    return s;
  endfunction

  function automatic bit exp_ready();
    int n;
    if (!reset_n) return 1'b0;
    n = (cur_q.size() == 0) ? (1 << cfg_mode[1:0]) : n_lat;
    return !((cur_q.size() + 1 == n) || t_0_last) || !mv || i_0_ready;
  endfunction

  task automatic model_reset();
    cur_q.delete();
    mv = 1'b0; mdat = '0; mbeats = 0; m_mode = 2'd0; n_lat = 1; mcnt = 0;
  endtask

  task automatic apply(input bit v, input logic [LW-1:0] d, input bit l, input logic [7:0] c, input bit r);
    t_0_valid = v; t_0_dat = d; t_0_last = l; cfg_mode = c; i_0_ready = r;
    #1;
  endtask

  task automatic clock_model();
    bit    acc_ok;
    word_t w;
    acc_ok = exp_ready();
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (mv && i_0_ready) begin
        w.d = mdat; w.b = mbeats; done_q.push_back(w); mv = 1'b0; mcnt++;
      end
      if (t_0_valid && acc_ok) begin
        if (cur_q.size() == 0) begin
          m_mode = cfg_mode[1:0];
          n_lat  = 1 << cfg_mode[1:0];
        end
        cur_q.push_back(t_0_dat);
        if (cur_q.size() == n_lat || t_0_last) begin
          mdat = '0;
          foreach (cur_q[k]) mdat[k*LW +: LW] = cur_q[k];
          mbeats = cur_q.size();
          mv = 1'b1;
          cur_q.delete();
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    apply(1'b1, 128'h55, 1'b0, 8'd3, 1'b1);
    checks++;
    if (t_0_ready !== 1'b0 || i_0_valid !== 1'b0 || i_0_dat !== '0 || i_0_beats !== 4'd0 || mode !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: got ready=%0b valid=%0b beats=%0d mode=%0d want all zero", t_0_ready, i_0_valid, i_0_beats, mode);
    end
`ifdef GATHER_CNT_EN
    checks++;
    if (i_0_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", i_0_cnt); end
`endif
    clock_model();
    reset_n = 1'b1;
    apply(1'b0, '0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic test_mode8();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    for (int i = 0; i < 8; i++) s.push_back(mk(1'b1, LW'(i + 1), 1'b0, 8'd3, 1'b1, 1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL mode8_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL mode8_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    e = '0;
    for (int k = 0; k < 8; k++) e[k*LW +: LW] = LW'(k + 1);
    checks++;
    if (i_0_valid !== 1'b1 || i_0_beats !== 4'd8 || i_0_dat !== e) begin
      errors++; $display("FAIL mode8_word: got v=%0b beats=%0d slot7=%h want v=1 beats=8 slot7=%h", i_0_valid, i_0_beats, i_0_dat[7*LW +: LW], e[7*LW +: LW]);
    end
    apply(1'b0, '0, 1'b0, 8'd3, 1'b1);
    clock_model();
  endtask

  task automatic test_mode2_stream();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    for (int i = 0; i < 6; i++) s.push_back(mk(1'b1, LW'(10 + i), 1'b0, 8'd1, 1'b1, 1));
    s.push_back(mk(1'b0, '0, 1'b0, 8'd1, 1'b1, -1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL mode2_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL mode2_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    checks++;
    if (done_q.size() != 3) begin errors++; $display("FAIL mode2_count: got %0d words want 3", done_q.size()); end
    for (int j = 0; j < 3 && j < done_q.size(); j++) begin
      e = '0;
      e[0 +: LW]  = LW'(10 + 2*j);
      e[LW +: LW] = LW'(11 + 2*j);
      checks++;
      if (done_q[j].d !== e || done_q[j].b != 2) begin
        errors++; $display("FAIL mode2_word %0d: got beats=%0d slot1=%h want beats=2 slot1=%h", j, done_q[j].b, done_q[j].d[LW +: LW], e[LW +: LW]);
      end
    end
  endtask

  task automatic test_last();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    s.push_back(mk(1'b1, 128'h11, 1'b0, 8'd3, 1'b1, 1));
    s.push_back(mk(1'b1, 128'h22, 1'b0, 8'd3, 1'b1, 1));
    s.push_back(mk(1'b1, 128'h33, 1'b1, 8'd3, 1'b1, 1));
    s.push_back(mk(1'b1, 128'h44, 1'b0, 8'd0, 1'b1, 1));
    s.push_back(mk(1'b0, '0, 1'b0, 8'd0, 1'b1, -1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL last_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL last_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    e = '0;
    e[0 +: LW] = 128'h11; e[LW +: LW] = 128'h22; e[2*LW +: LW] = 128'h33;
    checks++;
    if (done_q.size() < 2 || done_q[0].d !== e || done_q[0].b != 3) begin
      errors++; $display("FAIL last_early_word: got words=%0d want 2 with first beats=3 slots 3..7 zero", done_q.size());
    end
    e = '0;
    e[0 +: LW] = 128'h44;
    checks++;
    if (done_q.size() < 2 || done_q[1].d !== e || done_q[1].b != 1) begin
      errors++; $display("FAIL last_next_word: got words=%0d want second word beats=1 slot0=44", done_q.size());
    end
  endtask

  task automatic test_backpressure();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    for (int i = 0; i < 7; i++) s.push_back(mk(1'b1, LW'(i + 1), 1'b0, 8'd2, 1'b0, (i >= 4) ? 1 : -1));
    s.push_back(mk(1'b1, 128'h8, 1'b0, 8'd2, 1'b0, 0));
    s.push_back(mk(1'b1, 128'h8, 1'b0, 8'd2, 1'b0, 0));
    s.push_back(mk(1'b1, 128'h8, 1'b0, 8'd2, 1'b1, 1));
    s.push_back(mk(1'b0, '0, 1'b0, 8'd2, 1'b1, -1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL bp_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL bp_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    checks++;
    if (done_q.size() != 2) begin errors++; $display("FAIL bp_count: got %0d words want 2", done_q.size()); end
    for (int j = 0; j < 2 && j < done_q.size(); j++) begin
      e = '0;
      for (int k = 0; k < 4; k++) e[k*LW +: LW] = LW'(4*j + k + 1);
      checks++;
      if (done_q[j].d !== e || done_q[j].b != 4) begin
        errors++; $display("FAIL bp_word %0d: got beats=%0d slot3=%h want beats=4 slot3=%h", j, done_q[j].b, done_q[j].d[3*LW +: LW], e[3*LW +: LW]);
      end
    end
  endtask

  task automatic test_mode_change();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    for (int i = 0; i < 10; i++) s.push_back(mk(1'b1, LW'(i + 1), 1'b0, (i < 2) ? 8'd3 : 8'd0, 1'b1, 1));
    s.push_back(mk(1'b0, '0, 1'b0, 8'd0, 1'b1, -1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL mchg_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL mchg_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    e = '0;
    for (int k = 0; k < 8; k++) e[k*LW +: LW] = LW'(k + 1);
    checks++;
    if (done_q.size() != 3 || done_q[0].d !== e || done_q[0].b != 8) begin
      errors++; $display("FAIL mchg_word8: got words=%0d want 3 with first beats=8", done_q.size());
    end
    for (int j = 1; j < 3 && j < done_q.size(); j++) begin
      e = '0;
      e[0 +: LW] = LW'(8 + j);
      checks++;
      if (done_q[j].d !== e || done_q[j].b != 1) begin
        errors++; $display("FAIL mchg_word1 %0d: got beats=%0d slot0=%h want beats=1 slot0=%h", j, done_q[j].b, done_q[j].d[0 +: LW], e[0 +: LW]);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t        s[$];
    logic [W-1:0] e;
    done_q.delete();
    for (int i = 0; i < 5; i++) begin
      apply(1'b1, LW'(32'hE0 + i), 1'b0, 8'd3, 1'b1);
      clock_model();
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (i_0_valid !== 1'b0 || t_0_ready !== 1'b0 || mode !== 8'd0) begin
      errors++; $display("FAIL rstmid_state: got valid=%0b ready=%0b mode=%0d want 0 0 0", i_0_valid, t_0_ready, mode);
    end
    clock_model();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) s.push_back(mk(1'b1, LW'(i + 1), 1'b0, 8'd3, 1'b1, 1));
    s.push_back(mk(1'b0, '0, 1'b0, 8'd3, 1'b1, -1));
    foreach (s[i]) begin
      apply(s[i].v, s[i].d, s[i].l, s[i].c, s[i].r);
      checks++;
      if (t_0_ready !== exp_ready() || (s[i].er >= 0 && t_0_ready !== s[i].er[0])) begin
        errors++; $display("FAIL rstmid_ready beat %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL rstmid_out cycle %0d: got v=%0b beats=%0d mode=%0d want v=%0b beats=%0d mode=%0d", i, i_0_valid, i_0_beats, mode, mv, mbeats, m_mode);
      end
    end
    e = '0;
    for (int k = 0; k < 8; k++) e[k*LW +: LW] = LW'(k + 1);
    checks++;
    if (done_q.size() != 1 || done_q[0].d !== e || done_q[0].b != 8) begin
      errors++; $display("FAIL rstmid_word: got words=%0d want exactly 1 clean 8-beat word", done_q.size());
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] d;
    for (int i = 0; i < 600; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      apply($urandom_range(0, 3) != 0, d, $urandom_range(0, 7) == 0, 8'($urandom), (i >= 597) || ($urandom_range(0, 3) != 0));
      checks++;
      if (t_0_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready cycle %0d: got %0b want %0b", i, t_0_ready, exp_ready());
      end
      clock_model();
      checks++;
      if (i_0_valid !== mv || mode !== {6'b0, m_mode} || (mv && (i_0_dat !== mdat || i_0_beats !== 4'(mbeats)))) begin
        errors++; $display("FAIL rand_out cycle %0d: got v=%0b beats=%0d mode=%0d slot0=%h want v=%0b beats=%0d mode=%0d slot0=%h", i, i_0_valid, i_0_beats, mode, i_0_dat[0 +: LW], mv, mbeats, m_mode, mdat[0 +: LW]);
      end
`ifdef GATHER_CNT_EN
      checks++;
      if (i_0_cnt !== 16'(mcnt)) begin
        errors++; $display("FAIL rand_cnt cycle %0d: got %0d want %0d", i, i_0_cnt, 16'(mcnt));
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_mode8();
    test_mode2_stream();
    test_last();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
